// File: rtl/add_pipe.sv
// Pipelined segmented adder: S = A + B + CI over STAGES register stages.
// Each stage adds one segment with a parallel-prefix carry network.

module add_pipe_prefix #(
    parameter int N     = 16,
    parameter int SPEED = 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    localparam int LV = (N > 1) ? $clog2(N) : 0;

    logic [N-1:0] p;
    logic [N-1:0] gg;
    logic [N-1:0] pp;
    logic [N:0]   c;
    logic         unused_pp;

    // Carry-in is folded into bit 0, so gg[i] ends as the carry into bit i+1.
    always_comb begin
        int j;
        j     = 0;
        p     = a ^ b;
        gg    = a & b;
        pp    = p;
        gg[0] = gg[0] | (p[0] & ci);
        if (SPEED == 0) begin
            for (int i = 1; i < N; i++) begin
                gg[i] = gg[i] | (pp[i] & gg[i-1]);
                pp[i] = pp[i] & pp[i-1];
            end
        end else if (SPEED == 2) begin
            for (int l = 0; l < LV; l++) begin
                for (int i = 0; i < N; i++) begin
                    if (((i >> l) & 1) == 1) begin
                        j     = ((i >> (l + 1)) << (l + 1)) + (1 << l) - 1;
                        gg[i] = gg[i] | (pp[i] & gg[j]);
                        pp[i] = pp[i] & pp[j];
                    end
                end
            end
        end else begin
            for (int l = 0; l < LV; l++) begin
                for (int i = 0; i < N; i++) begin
                    if (((i + 1) % (2 << l)) == 0) begin
                        j     = i - (1 << l);
                        gg[i] = gg[i] | (pp[i] & gg[j]);
                        pp[i] = pp[i] & pp[j];
                    end
                end
            end
            for (int l = LV - 2; l >= 0; l--) begin
                for (int i = 0; i < N; i++) begin
                    if ((((i + 1) % (2 << l)) == (1 << l)) && (i > (1 << l))) begin
                        j     = i - (1 << l);
                        gg[i] = gg[i] | (pp[i] & gg[j]);
                        pp[i] = pp[i] & pp[j];
                    end
                end
            end
        end
        c      = '0;
        c[0]   = ci;
        c[N:1] = gg;
    end

    assign s         = p ^ c[N-1:0];
    assign co        = c[N];
    assign unused_pp = ^pp;

endmodule

module add_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int SPEED  = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             ci_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             co_o
);
    localparam int SEG = WIDTH / STAGES;

    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] c_r;
    logic [WIDTH-1:0]  a_r [STAGES];
    logic [WIDTH-1:0]  b_r [STAGES];
    logic [WIDTH-1:0]  s_r [STAGES];
    logic              unused_ab;

    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = ~v[k] | rdy[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             up_v;
        logic             up_c;
        logic [WIDTH-1:0] up_a;
        logic [WIDTH-1:0] up_b;
        logic [WIDTH-1:0] up_s;
        logic [WIDTH-1:0] nxt_s;
        logic [SEG-1:0]   seg_s;
        logic             seg_c;
        logic             v_q;
        logic             c_q;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;

        if (k == 0) begin : g_head
            assign up_v = in_valid_i;
            assign up_c = ci_i;
            assign up_a = a_i;
            assign up_b = b_i;
            assign up_s = '0;
        end else begin : g_link
            assign up_v = v[k-1];
            assign up_c = c_r[k-1];
            assign up_a = a_r[k-1];
            assign up_b = b_r[k-1];
            assign up_s = s_r[k-1];
        end

        add_pipe_prefix #(
            .N     (SEG),
            .SPEED (SPEED)
        ) u_add (
            .a  (up_a[k*SEG +: SEG]),
            .b  (up_b[k*SEG +: SEG]),
            .ci (up_c),
            .s  (seg_s),
            .co (seg_c)
        );

        always_comb begin
            nxt_s                = up_s;
            nxt_s[k*SEG +: SEG]  = seg_s;
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
            end else begin
                if (rdy[k]) begin
                    v_q <= up_v;
                end
                if (rdy[k] && up_v) begin
                    c_q <= seg_c;
                    a_q <= up_a;
                    b_q <= up_b;
                    s_q <= nxt_s;
                end
            end
        end

        assign v[k]   = v_q;
        assign c_r[k] = c_q;
        assign a_r[k] = a_q;
        assign b_r[k] = b_q;
        assign s_r[k] = s_q;
    end

    assign in_ready_o  = rdy[0];
    assign out_valid_o = v[STAGES-1];
    assign s_o         = s_r[STAGES-1];
    assign co_o        = c_r[STAGES-1];
    assign unused_ab   = ^{a_r[STAGES-1], b_r[STAGES-1]};

endmodule

// File: tb/tb_add_pipe.sv
// Randomized scoreboard bench for add_pipe over several WIDTH/STAGES/SPEED
// variants driven from one shared operand stream.

module tb_add_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        bb = 1'b0;
    logic        endchk = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rnd();
        a  = $urandom;
        b  = $urandom;
        ci = 1'($urandom & 1);
    endtask

    for (genvar G = 0; G < 6; G++) begin : g_dut
        localparam int W  = (G == 5) ? 8 : 32;
        localparam int S  = (G == 3) ? 1 : (G == 4) ? 4 : (G == 5) ? 8 : 2;
        localparam int SP = (G == 1) ? 0 : (G == 2 || G == 5) ? 2 : 1;

        logic         rdy;
        logic         ov;
        logic         co;
        logic [W-1:0] s;
        logic [W:0]   q[$];
        logic [W:0]   hv;
        logic [W:0]   e;
        logic         held;
        int           cnt;

        add_pipe #(
            .WIDTH  (W),
            .STAGES (S),
            .SPEED  (SP)
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .in_valid_i  (in_valid),
            .in_ready_o  (rdy),
            .a_i         (a[W-1:0]),
            .b_i         (b[W-1:0]),
            .ci_i        (ci),
            .out_valid_o (ov),
            .out_ready_i (out_ready),
            .s_o         (s),
            .co_o        (co)
        );

        always @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q.delete();
                held = 1'b0;
                cnt  = 0;
            end else begin
                if (endchk) check($sformatf("i%0d_left", G), q.size(), 0);
                if (bb) begin
                    cnt++;
                    check($sformatf("i%0d_bb_rdy", G), rdy, 1);
                    if (cnt > S) check($sformatf("i%0d_bb_ov", G), ov, 1);
                end else begin
                    cnt = 0;
                end
                if (held && ov) check($sformatf("i%0d_hold", G), {co, s}, hv);
                held = ov && !out_ready;
                hv   = {co, s};
                if (ov && out_ready) begin
                    if (q.size() == 0) begin
                        check($sformatf("i%0d_extra", G), 1, 0);
                    end else begin
                        e = q.pop_front();
                        check($sformatf("i%0d_sum", G), {co, s}, e);
                    end
                end
                if (in_valid && rdy) begin
                    e = {1'b0, a[W-1:0]} + {1'b0, b[W-1:0]} + {{W{1'b0}}, ci};
                    q.push_back(e);
                end
            end
        end
    end

    initial begin
        int          n;
        int          acc;
        int          cyc;
        bit          tk;
        logic [32:0] ex;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ov", g_dut[0].ov, 0);
        check("rst_rdy", g_dut[0].rdy, 1);
        check("rst_s", g_dut[0].s, 0);
        check("rst_co", g_dut[0].co, 0);
        check("rst_ov8", g_dut[5].ov, 0);
        check("rst_rdy8", g_dut[5].rdy, 1);

        // carry across the 16-bit segment boundary
        @(posedge clk); #1;
        in_valid = 1'b1; a = 32'h0000_FFFF; b = 32'h0000_0001; ci = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("seg_ov", g_dut[0].ov, 1);
        check("seg_s", g_dut[0].s, 32'h0001_0000);
        check("seg_co", g_dut[0].co, 0);
        repeat (10) @(posedge clk);
        #1;

        in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h0; ci = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("wrap_ov", g_dut[0].ov, 1);
        check("wrap_s", g_dut[0].s, 32'h0);
        check("wrap_co", g_dut[0].co, 1);
        repeat (10) @(posedge clk);
        #1;

        // backpressure: five beats offered, consumer stalled six cycles
        out_ready = 1'b0;
        n = 0;
        in_valid = 1'b1;
        rnd();
        repeat (6) begin
            @(negedge clk);
            tk = in_valid && g_dut[0].rdy;
            @(posedge clk); #1;
            if (tk) begin
                n++;
                rnd();
            end
        end
        check("bp_taken", n, 2);
        check("bp_rdy", g_dut[0].rdy, 0);
        out_ready = 1'b1;
        cyc = 0;
        while (n < 5 && cyc < 50) begin
            @(negedge clk);
            tk = in_valid && g_dut[0].rdy;
            @(posedge clk); #1;
            cyc++;
            if (tk) begin
                n++;
                rnd();
            end
        end
        in_valid = 1'b0;
        check("bp_done", n, 5);
        repeat (20) @(posedge clk);
        #1;

        // back-to-back stream
        bb = 1'b1;
        repeat (100) begin
            in_valid = 1'b1;
            rnd();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        bb = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // reset with two beats in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        rnd();
        @(posedge clk); #1;
        rnd();
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("mid_full", g_dut[0].ov, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_ov", g_dut[0].ov, 0);
        check("mid_ov1", g_dut[3].ov, 0);
        check("mid_s", g_dut[0].s, 0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; a = 32'h1234_5678; b = 32'h9ABC_DEF0; ci = 1'b1;
        ex = {1'b0, a} + {1'b0, b} + 33'(ci);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("post_ov", g_dut[0].ov, 1);
        check("post_sum", {g_dut[0].co, g_dut[0].s}, ex);
        repeat (20) @(posedge clk);
        #1;

        // random valid/ready, paced by the 8x1-bit pipe
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            @(negedge clk);
            tk = in_valid && g_dut[5].rdy;
            if (tk) acc++;
            @(posedge clk); #1;
            cyc++;
            out_ready = ($urandom % 4) != 0;
            if (!in_valid || tk) begin
                in_valid = ($urandom % 4) != 0;
                rnd();
            end
        end
        check("rand_beats", acc, 10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        endchk = 1'b1;
        @(negedge clk);
        #1;
        endchk = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
